// File: rtl/button_event.sv
// rtl/button_event.sv - per-button press/release/short/long/repeat event classifier
module button_event #(
    parameter int unsigned N             = 2,
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] ev_press,
    output logic [N-1:0] ev_release,
    output logic [N-1:0] ev_short,
    output logic [N-1:0] ev_long,
    output logic [N-1:0] ev_repeat,
    output logic [N-1:0] held
);

    localparam int unsigned MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int          CW         = $clog2(MAX_CYCLES + 1);

    // Terminal counts; a disabled repeat period collapses to 0 so no negative value is formed.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = (REPEAT_CYCLES == 0) ? '0 : CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        DOWN = 2'd2,
        HELD = 2'd3
    } state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_d, rel_d, short_d, long_d, rpt_d;
        logic          press_q, rel_q, short_q, long_q, rpt_q;

        // Next-state, counter and event decode; release always wins over long/repeat.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            short_d = 1'b0;
            long_d  = 1'b0;
            rpt_d   = 1'b0;
            case (state_q)
                ARM: begin
                    if (!btn[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                IDLE: begin
                    if (btn[i]) begin
                        state_d = DOWN;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                DOWN: begin
                    if (!btn[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                        short_d = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!btn[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                    end else if (REPEAT_CYCLES == 0) begin
                        cnt_d = '0;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            endcase
        end

        // State, counter and registered event pulses; reset aborts any press silently.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ARM;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                short_q <= 1'b0;
                long_q  <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                short_q <= short_d;
                long_q  <= long_d;
                rpt_q   <= rpt_d;
            end
        end

        assign ev_press[i]   = press_q;
        assign ev_release[i] = rel_q;
        assign ev_short[i]   = short_q;
        assign ev_long[i]    = long_q;
        assign ev_repeat[i]  = rpt_q;
        assign held[i]       = (state_q == HELD);
    end

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - scoreboard bench for button_event
module tb_button_event;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_a, btn_b;
    logic [N-1:0] press_a, rel_a, short_a, long_a, rpt_a, held_a;
    logic [N-1:0] press_b, rel_b, short_b, long_b, rpt_b, held_b;

    typedef struct {
        int             cyc;
        logic [6*N-1:0] vec;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   e0;

    button_event #(.N(N), .LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .btn(btn_a),
        .ev_press(press_a), .ev_release(rel_a), .ev_short(short_a),
        .ev_long(long_a), .ev_repeat(rpt_a), .held(held_a)
    );

    button_event #(.N(N), .LONG_CYCLES(8), .REPEAT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .btn(btn_b),
        .ev_press(press_b), .ev_release(rel_b), .ev_short(short_b),
        .ev_long(long_b), .ev_repeat(rpt_b), .held(held_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic cmp_ev(input string name, input exp_t e, input logic [6*N-1:0] got);
        checks++;
        if (e.cyc != cyc || e.vec !== got) begin
            failures++;
            $display("FAIL %s event: got cyc=%0d vec=%b, want cyc=%0d vec=%b", name, cyc, got, e.cyc, e.vec);
        end
    endtask

    // vec layout: {press, release, short, long, repeat, held}
    task automatic exp_a(input int c, input logic [N-1:0] p, input logic [N-1:0] r, input logic [N-1:0] s,
                         input logic [N-1:0] l, input logic [N-1:0] rp, input logic [N-1:0] h);
        exp_t t;
        t.cyc = c;
        t.vec = {p, r, s, l, rp, h};
        q_a.push_back(t);
    endtask

    task automatic exp_b(input int c, input logic [N-1:0] p, input logic [N-1:0] r, input logic [N-1:0] s,
                         input logic [N-1:0] l, input logic [N-1:0] rp, input logic [N-1:0] h);
        exp_t t;
        t.cyc = c;
        t.vec = {p, r, s, l, rp, h};
        q_b.push_back(t);
    endtask

    // Monitor: any event pulse pops the next expectation and compares cycle and full output vector.
    always @(negedge clk) begin
        if (rst) begin
            if (|{press_a, rel_a, short_a, long_a, rpt_a}) begin
                if (q_a.size() == 0) begin
                    e_a.cyc = -1;
                    e_a.vec = '0;
                end else begin
                    e_a = q_a.pop_front();
                end
                cmp_ev("dut_a", e_a, {press_a, rel_a, short_a, long_a, rpt_a, held_a});
            end
            if (|{press_b, rel_b, short_b, long_b, rpt_b}) begin
                if (q_b.size() == 0) begin
                    e_b.cyc = -1;
                    e_b.vec = '0;
                end else begin
                    e_b = q_b.pop_front();
                end
                cmp_ev("dut_b", e_b, {press_b, rel_b, short_b, long_b, rpt_b, held_b});
            end
        end
    end

    initial begin
        rst   = 1'b0;
        btn_a = '0;
        btn_b = '0;
        step(3);
        chk("reset_state_a", 32'({press_a, rel_a, short_a, long_a, rpt_a, held_a}), 32'd0);
        chk("reset_state_b", 32'({press_b, rel_b, short_b, long_b, rpt_b, held_b}), 32'd0);
        rst = 1'b1;
        step(2);

        // Short press: high edges 0-2, low at 3.
        btn_a = 2'b01; e0 = cyc + 1;
        exp_a(e0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(3); btn_a = 2'b00;
        exp_a(e0 + 3, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        step(3);

        // Long press with auto-repeat: high edges 0-19, low at 20.
        btn_a = 2'b01; e0 = cyc + 1;
        exp_a(e0,      2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        exp_a(e0 + 8,  2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        exp_a(e0 + 12, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
        exp_a(e0 + 16, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
        step(20); btn_a = 2'b00;
        exp_a(e0 + 20, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        step(3);

        // Release exactly on the long threshold edge: short+release, no long.
        btn_a = 2'b01; e0 = cyc + 1;
        exp_a(e0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(8); btn_a = 2'b00;
        exp_a(e0 + 8, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        step(3);

        // Reset at edge 5 of a press; button held through reset must be released first.
        btn_a = 2'b01; e0 = cyc + 1;
        exp_a(e0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(5); rst = 1'b0; #1;
        chk("rst_clear_down", 32'({press_a, rel_a, short_a, long_a, rpt_a, held_a}), 32'd0);
        step(2); rst = 1'b1;
        step(5); btn_a = 2'b00;
        step(1); btn_a = 2'b01; e0 = cyc + 1;
        exp_a(e0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(2); btn_a = 2'b00;
        exp_a(e0 + 2, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        step(3);

        // Reset while HELD: held must drop immediately.
        btn_a = 2'b01; e0 = cyc + 1;
        exp_a(e0,     2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        exp_a(e0 + 8, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        step(10);
        chk("held_before_rst", 32'(held_a), 32'd1);
        rst = 1'b0; #1;
        chk("rst_clear_held", 32'({press_a, rel_a, short_a, long_a, rpt_a, held_a}), 32'd0);
        btn_a = 2'b00;
        step(1); rst = 1'b1;
        step(3);

        // Two channels pressed together, released independently.
        btn_a = 2'b11; e0 = cyc + 1;
        exp_a(e0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(3); btn_a = 2'b01;
        exp_a(e0 + 3, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        exp_a(e0 + 8, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        step(7); btn_a = 2'b00;
        exp_a(e0 + 10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        step(3);

        // Back-to-back: one-cycle low gap gives release then press on consecutive cycles.
        btn_a = 2'b01; e0 = cyc + 1;
        exp_a(e0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(2); btn_a = 2'b00;
        exp_a(e0 + 2, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        step(1); btn_a = 2'b01;
        exp_a(e0 + 3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        step(2); btn_a = 2'b00;
        exp_a(e0 + 5, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        step(3);

        // Repeat disabled: 30-edge hold gives press, long, release only.
        btn_b = 2'b01; e0 = cyc + 1;
        exp_b(e0,     2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        exp_b(e0 + 8, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        step(30); btn_b = 2'b00;
        exp_b(e0 + 30, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        step(4);

        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event.md
# button_event

Per-button event classifier that sits directly downstream of the `debounce` stage. Takes the clean, clk-synchronous pressed/not-pressed level of each button and turns it into single-cycle event pulses: press, release, short press, long press and auto-repeat. Also gives a held level. Consumers such as LED, menu and counter logic use these pulses instead of decoding raw levels.

## Interface
- `N`, default 2: number of independent button channels.
- `LONG_CYCLES`, default 50_000_000: cycles from press to long-press event (0.5 s at 100 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period while held after long press; 0 disables repeat.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `btn` input N: debounced level per channel, 1 = pressed; already synchronous to `clk`.
- `ev_press` output N: 1-cycle pulse on accepted press.
- `ev_release` output N: 1-cycle pulse on release of an accepted press.
- `ev_short` output N: 1-cycle pulse, released before long threshold.
- `ev_long` output N: 1-cycle pulse, long threshold reached while pressed.
- `ev_repeat` output N: 1-cycle pulse every `REPEAT_CYCLES` while in HELD.
- `held` output N: level, 1 while channel is in HELD.

## Operation
- N identical channels, fully independent. Each has its own FSM and counter; no shared state.
- Counter width is `$clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1)`. Counter is cleared on every state entry and never wraps.
- FSM states per channel:
  - ARM, the reset state: `btn`=0 → IDLE; `btn`=1 → stay, no events. A button held through reset must be released first.
  - IDLE: `btn`=1 → DOWN, pulse `ev_press`.
  - DOWN: `btn`=0 → IDLE, pulse `ev_release` and `ev_short`. Counter reaches `LONG_CYCLES-1` with `btn`=1 → HELD, pulse `ev_long`. Otherwise the counter increments.
  - HELD: `btn`=0 → IDLE, pulse `ev_release`. If `REPEAT_CYCLES`≠0 and counter reaches `REPEAT_CYCLES-1` with `btn`=1, pulse `ev_repeat`, clear the counter and stay. Otherwise the counter increments. With `REPEAT_CYCLES`=0 the counter stays at 0.
- Priority: release beats long and repeat in the same cycle. A release coinciding with the long threshold gives short+release and no long. A release coinciding with a repeat gives release only.
- `ev_short` and `ev_long` are mutually exclusive per press. Exactly one `ev_release` follows every `ev_press`, unless reset intervenes.
- Reset (`rst`=0) at any time:
  - all outputs go to 0 immediately;
  - all FSMs go to ARM and counters to 0;
  - no release or short event is emitted for an aborted press.

## Timing
- All outputs are registered and change only on rising `clk`, except for the asynchronous clear.
- Reset value of every output is 0.
- Let edge 0 be the first rising edge that samples `btn`=1 in IDLE:
  - `ev_press` is high for the cycle after edge 0;
  - `ev_long` follows edge `LONG_CYCLES`;
  - `ev_repeat` follows edges `LONG_CYCLES + k·REPEAT_CYCLES`, k ≥ 1;
  - `held` rises with `ev_long` and falls with `ev_release`.
- Release latency: the edge sampling `btn`=0 produces `ev_release` (and `ev_short` if applicable) in the following cycle.
- Back-to-back: IDLE accepts a new press on the edge right after the release edge, so a 1-cycle-low gap gives release then press on consecutive cycles.
- Each pulse is exactly 1 cycle wide. No event repeats without a new threshold crossing.

## Test plan
Bench parameters: N=2, LONG_CYCLES=8, REPEAT_CYCLES=4.
- `btn[0]` high for edges 0–2, low from edge 3 → `ev_press[0]` after edge 0. `ev_release[0]` and `ev_short[0]` after edge 3. No `ev_long`, `held` stays 0.
- `btn[0]` high for edges 0–19, low at 20 → events as follows:
  - press after edge 0;
  - long after edge 8, with `held[0]` high from then;
  - repeat after edges 12 and 16;
  - release only after edge 20, no repeat at 20;
  - `held[0]` low after edge 20.
- `btn[0]` high for edges 0–7, low at edge 8 → short+release after edge 8, no `ev_long`.
- `rst`=0 at edge 5 of a press with `btn` still high → all outputs 0 immediately. After `rst` deasserts, no events while `btn` stays high. Release then press again → `ev_press` after the re-press edge.
- `btn[0]` and `btn[1]` rise on the same edge; `btn[1]` releases at edge 3, `btn[0]` at edge 10 → ch1 short+release after edge 3; ch0 long after edge 8 and release after edge 10, with no cross-talk.
- Rebuild with REPEAT_CYCLES=0, hold `btn[0]` for 30 edges → exactly one press, one long and one release; `ev_repeat` never asserts.
